// File: rtl/game_pkg.sv
// Shared GameBox constants and the frame-sequencer state encoding.
package game_pkg;

    localparam int unsigned SCR_W_DEF    = 30;
    localparam int unsigned SCR_H_DEF    = 30;
    localparam int unsigned TICK_DIV_DEF = 50;
    localparam int unsigned FRAME_CW     = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SAMPLE = 3'd1,
        PHYS   = 3'd2,
        COLL   = 3'd3,
        RENDER = 3'd4,
        DONE   = 3'd5
    } sched_state_t;

endpackage

// File: rtl/tick_divider.sv
// Free-running divider: raises tick_c for one cycle every TICK_DIV clocks.
module tick_divider #(
    parameter  int unsigned TICK_DIV = 50,
    localparam int unsigned CW       = $clog2(TICK_DIV)
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_c
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_c = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/game_tick_scheduler.sv
// Per-tick frame sequencer: sample input, kick physics and collision, then raster the screen.
module game_tick_scheduler
    import game_pkg::*;
#(
    parameter  int unsigned SCR_W    = SCR_W_DEF,
    parameter  int unsigned SCR_H    = SCR_H_DEF,
    parameter  int unsigned TICK_DIV = TICK_DIV_DEF,
    localparam int unsigned XW       = $clog2(SCR_W),
    localparam int unsigned YW       = $clog2(SCR_H)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                left,
    input  logic                right,
    input  logic                game_over,
    input  logic                physics_done,
    input  logic                collide_done,
    input  logic                render_ready,
    input  logic                clr_overrun,
    output logic                move_left,
    output logic                move_right,
    output logic                physics_update,
    output logic                collide_start,
    output logic                pix_valid,
    output logic [XW-1:0]       pix_x,
    output logic [YW-1:0]       pix_y,
    output logic                frame_done,
    output logic [FRAME_CW-1:0] frame_cnt,
    output logic                overrun,
    output logic                busy
);

    sched_state_t state_q, state_d;

    logic                move_left_q,      move_left_d;
    logic                move_right_q,     move_right_d;
    logic                physics_update_q, physics_update_d;
    logic                collide_start_q,  collide_start_d;
    logic                pix_valid_q,      pix_valid_d;
    logic [XW-1:0]       pix_x_q,          pix_x_d;
    logic [YW-1:0]       pix_y_q,          pix_y_d;
    logic                frame_done_q,     frame_done_d;
    logic [FRAME_CW-1:0] frame_cnt_q,      frame_cnt_d;
    logic                overrun_q,        overrun_d;
    logic                busy_q,           busy_d;

    logic tick_c;
    logic accept_c;
    logic last_col_c;
    logic last_row_c;

    tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk    (clk),
        .rst_n  (reset),
        .tick_c (tick_c)
    );

    assign accept_c   = pix_valid_q & render_ready;
    assign last_col_c = (pix_x_q == XW'(SCR_W - 1));
    assign last_row_c = (pix_y_q == YW'(SCR_H - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The start pulse register marks the first PHYS/COLL cycle, so a done in that cycle is ignored.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (tick_c && !game_over) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: state_d = PHYS;
            PHYS: begin
                if (!physics_update_q && physics_done) begin
                    state_d = COLL;
                end
            end
            COLL: begin
                if (!collide_start_q && collide_done) begin
                    state_d = RENDER;
                end
            end
            RENDER: begin
                if (accept_c && last_col_c && last_row_c) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        move_left_d      = move_left_q;
        move_right_d     = move_right_q;
        physics_update_d = (state_q == SAMPLE);
        collide_start_d  = (state_q == PHYS) && (state_d == COLL);
        pix_valid_d      = (state_d == RENDER);
        pix_x_d          = pix_x_q;
        pix_y_d          = pix_y_q;
        frame_done_d     = (state_d == DONE);
        frame_cnt_d      = frame_cnt_q;
        overrun_d        = overrun_q;
        busy_d           = (state_d != IDLE);

        if (state_q == SAMPLE) begin
            move_left_d  = left & ~right;
            move_right_d = right & ~left;
        end

        // Raster walks row-major on each accepted pixel and parks at the origin outside RENDER.
        if (state_d != RENDER) begin
            pix_x_d = '0;
            pix_y_d = '0;
        end else if (accept_c) begin
            if (last_col_c) begin
                pix_x_d = '0;
                pix_y_d = pix_y_q + YW'(1);
            end else begin
                pix_x_d = pix_x_q + XW'(1);
            end
        end

        if (frame_done_d) begin
            frame_cnt_d = frame_cnt_q + FRAME_CW'(1);
        end

        if (tick_c && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            move_left_q      <= 1'b0;
            move_right_q     <= 1'b0;
            physics_update_q <= 1'b0;
            collide_start_q  <= 1'b0;
            pix_valid_q      <= 1'b0;
            pix_x_q          <= '0;
            pix_y_q          <= '0;
            frame_done_q     <= 1'b0;
            frame_cnt_q      <= '0;
            overrun_q        <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            move_left_q      <= move_left_d;
            move_right_q     <= move_right_d;
            physics_update_q <= physics_update_d;
            collide_start_q  <= collide_start_d;
            pix_valid_q      <= pix_valid_d;
            pix_x_q          <= pix_x_d;
            pix_y_q          <= pix_y_d;
            frame_done_q     <= frame_done_d;
            frame_cnt_q      <= frame_cnt_d;
            overrun_q        <= overrun_d;
            busy_q           <= busy_d;
        end
    end

    assign move_left      = move_left_q;
    assign move_right     = move_right_q;
    assign physics_update = physics_update_q;
    assign collide_start  = collide_start_q;
    assign pix_valid      = pix_valid_q;
    assign pix_x          = pix_x_q;
    assign pix_y          = pix_y_q;
    assign frame_done     = frame_done_q;
    assign frame_cnt      = frame_cnt_q;
    assign overrun        = overrun_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with a 4x3 screen and a 32-cycle tick.
module tb_game_tick_scheduler;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic left = 1'b0, right = 1'b0, game_over = 1'b0;
    logic physics_done = 1'b0, collide_done = 1'b0, render_ready = 1'b0, clr_overrun = 1'b0;
    logic move_left, move_right, physics_update, collide_start, pix_valid;
    logic [1:0] pix_x, pix_y;
    logic frame_done;
    logic [15:0] frame_cnt;
    logic overrun, busy;
    logic [27:0] outs;

    int checks = 0;
    int failures = 0;
    int cyc, pu_cnt, pu_cyc, fd_cnt, fd_cyc, phys_cnt, coll_cnt, first_acc, last_acc, hold_err;
    bit phys_en, rr_toggle, ok;
    logic [1:0] acc_x[$];
    logic [1:0] acc_y[$];

    assign outs = {move_left, move_right, physics_update, collide_start, pix_valid, pix_x, pix_y,
                   frame_done, frame_cnt, overrun, busy};

    always #5 clk = ~clk;

    game_tick_scheduler #(.SCR_W(4), .SCR_H(3), .TICK_DIV(32)) dut (
        .clk(clk), .reset(reset), .left(left), .right(right), .game_over(game_over),
        .physics_done(physics_done), .collide_done(collide_done), .render_ready(render_ready),
        .clr_overrun(clr_overrun), .move_left(move_left), .move_right(move_right),
        .physics_update(physics_update), .collide_start(collide_start), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .overrun(overrun), .busy(busy)
    );

    // One clock: log accepted pixels, then emulate physics/collision units answering 3 cycles after a pulse.
    task automatic step();
        logic hchk;
        logic [1:0] hx, hy;
        hchk = pix_valid && !render_ready;
        hx = pix_x;
        hy = pix_y;
        if (pix_valid && render_ready) begin
            acc_x.push_back(pix_x);
            acc_y.push_back(pix_y);
            if (acc_x.size() == 1) first_acc = cyc;
            last_acc = cyc;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (hchk && pix_valid && (pix_x !== hx || pix_y !== hy)) hold_err++;
        if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
        if (physics_update) begin pu_cnt++; pu_cyc = cyc; end
        physics_done = 1'b0;
        collide_done = 1'b0;
        if (phys_cnt > 0) begin
            phys_cnt--;
            if (phys_cnt == 0 && phys_en) physics_done = 1'b1;
        end
        if (coll_cnt > 0) begin
            coll_cnt--;
            if (coll_cnt == 0) collide_done = 1'b1;
        end
        if (physics_update) phys_cnt = 3;
        if (collide_start) coll_cnt = 3;
        if (rr_toggle) render_ready = !render_ready;
    endtask

    task automatic run_to(input int c);
        for (int i = 0; i < 1000 && cyc < c; i++) step();
    endtask

    task automatic wait_frame(input int bound, output bit done);
        int start;
        start = fd_cnt;
        done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (fd_cnt != start) begin done = 1'b1; break; end
        end
    endtask

    // Holds reset across an edge and releases it on a falling edge; that cycle is cycle 0.
    task automatic do_reset();
        reset = 1'b0;
        left = 1'b0; right = 1'b0; game_over = 1'b0; clr_overrun = 1'b0;
        physics_done = 1'b0; collide_done = 1'b0; render_ready = 1'b1;
        phys_en = 1'b1; rr_toggle = 1'b0;
        pu_cnt = 0; pu_cyc = -1; fd_cnt = 0; fd_cyc = -1; phys_cnt = 0; coll_cnt = 0;
        first_acc = -1; last_acc = -1; hold_err = 0;
        acc_x.delete(); acc_y.delete();
        #12;
        @(negedge clk);
        reset = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        int nz;
        reset = 1'b0;
        #3;
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL reset_outs: got %h expected 0", outs); end
        do_reset();
        nz = 0;
        if (outs !== '0) nz++;
        for (int i = 0; i < 31; i++) begin step(); if (outs !== '0) nz++; end
        checks++;
        if (nz != 0) begin failures++; $display("FAIL pre_tick_quiet: got %0d nonzero cycles expected 0", nz); end
        run_to(32);
        checks++;
        if (busy !== 1'b1 || physics_update !== 1'b0) begin
            failures++; $display("FAIL sample_cycle: got busy=%b pu=%b expected busy=1 pu=0", busy, physics_update);
        end
        run_to(40);
        checks++;
        if (pu_cnt != 1 || pu_cyc != 33) begin
            failures++; $display("FAIL physics_pulse: got count=%0d cycle=%0d expected 1 at 33", pu_cnt, pu_cyc);
        end
        wait_frame(60, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL first_frame: got no frame_done expected one"); end
    endtask

    task automatic test_move();
        do_reset();
        left = 1'b1;
        run_to(34);
        checks++;
        if (move_left !== 1'b1 || move_right !== 1'b0) begin
            failures++; $display("FAIL move_left_only: got %b%b expected 10", move_left, move_right);
        end
        left = 1'b0;
        run_to(40);
        checks++;
        if (move_left !== 1'b1) begin failures++; $display("FAIL move_hold: got %b expected 1", move_left); end
        run_to(60);
        left = 1'b1; right = 1'b1;
        run_to(66);
        checks++;
        if (move_left !== 1'b0 || move_right !== 1'b0) begin
            failures++; $display("FAIL move_both: got %b%b expected 00", move_left, move_right);
        end
        left = 1'b0; right = 1'b1;
        run_to(98);
        checks++;
        if (move_left !== 1'b0 || move_right !== 1'b1) begin
            failures++; $display("FAIL move_right_only: got %b%b expected 01", move_left, move_right);
        end
    endtask

    task automatic test_render();
        do_reset();
        run_to(60);
        checks++;
        if (acc_x.size() != 12) begin
            failures++; $display("FAIL render_count: got %0d expected 12", acc_x.size());
        end
        for (int i = 0; i < 12; i++) begin
            logic [1:0] ex, ey;
            ex = 2'(i % 4);
            ey = 2'(i / 4);
            checks++;
            if (i >= acc_x.size()) begin
                failures++; $display("FAIL render_px%0d: got none expected (%0d,%0d)", i, ex, ey);
            end else if (acc_x[i] !== ex || acc_y[i] !== ey) begin
                failures++;
                $display("FAIL render_px%0d: got (%0d,%0d) expected (%0d,%0d)", i, acc_x[i], acc_y[i], ex, ey);
            end
        end
        checks++;
        if (first_acc != 41 || last_acc != 52) begin
            failures++; $display("FAIL render_window: got %0d..%0d expected 41..52", first_acc, last_acc);
        end
        checks++;
        if (fd_cnt != 1 || fd_cyc != 53 || frame_cnt !== 16'd1) begin
            failures++;
            $display("FAIL frame_done: got n=%0d at %0d cnt=%0d expected n=1 at 53 cnt=1", fd_cnt, fd_cyc, frame_cnt);
        end
        checks++;
        if (pix_valid !== 1'b0 || pix_x !== 2'd0 || pix_y !== 2'd0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL render_exit: got v=%b x=%0d y=%0d busy=%b expected all 0", pix_valid, pix_x, pix_y, busy);
        end
    endtask

    task automatic test_render_stall();
        int bad;
        do_reset();
        rr_toggle = 1'b1;
        run_to(80);
        bad = 0;
        for (int i = 0; i < acc_x.size(); i++) begin
            if (acc_x[i] !== 2'(i % 4) || acc_y[i] !== 2'(i / 4)) bad++;
        end
        checks++;
        if (acc_x.size() != 12 || bad != 0) begin
            failures++; $display("FAIL stall_pixels: got n=%0d bad=%0d expected n=12 bad=0", acc_x.size(), bad);
        end
        checks++;
        if (hold_err != 0) begin failures++; $display("FAIL stall_hold: got %0d moves expected 0", hold_err); end
        checks++;
        if (fd_cnt != 1 || fd_cyc != 65 || frame_cnt !== 16'd1) begin
            failures++;
            $display("FAIL stall_done: got n=%0d at %0d cnt=%0d expected n=1 at 65 cnt=1", fd_cnt, fd_cyc, frame_cnt);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        phys_en = 1'b0;
        run_to(63);
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL overrun_pre: got ov=%b busy=%b expected ov=0 busy=1", overrun, busy);
        end
        run_to(64);
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set: got %b expected 1", overrun); end
        run_to(72);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_clr: got %b expected 0", overrun); end
        run_to(95);
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_tick_wins: got %b expected 1", overrun); end
        clr_overrun = 1'b1;
        step();
        clr_overrun = 1'b0;
        physics_done = 1'b1;
        wait_frame(40, ok);
        checks++;
        if (!ok || fd_cyc != 114 || frame_cnt !== 16'd1) begin
            failures++; $display("FAIL overrun_frame: got done at %0d cnt=%0d expected 114 cnt=1", fd_cyc, frame_cnt);
        end
        run_to(130);
        checks++;
        if (overrun !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL idle_tick: got ov=%b busy=%b expected ov=0 busy=1", overrun, busy);
        end
    endtask

    task automatic test_game_over();
        do_reset();
        game_over = 1'b1;
        run_to(40);
        checks++;
        if (busy !== 1'b0 || pu_cnt != 0 || overrun !== 1'b0) begin
            failures++; $display("FAIL game_over_drop: got busy=%b pu=%0d ov=%b expected 0", busy, pu_cnt, overrun);
        end
        game_over = 1'b0;
        run_to(66);
        game_over = 1'b1;
        wait_frame(40, ok);
        checks++;
        if (!ok || fd_cyc != 85 || frame_cnt !== 16'd1) begin
            failures++; $display("FAIL game_over_mid: got done at %0d cnt=%0d expected 85 cnt=1", fd_cyc, frame_cnt);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        run_to(47);
        checks++;
        if (pix_valid !== 1'b1 || pix_x !== 2'd2 || pix_y !== 2'd1) begin
            failures++; $display("FAIL mid_position: got v=%b (%0d,%0d) expected v=1 (2,1)", pix_valid, pix_x, pix_y);
        end
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== '0) begin failures++; $display("FAIL mid_reset_outs: got %h expected 0", outs); end
        do_reset();
        step();
        checks++;
        if (busy !== 1'b0 || frame_cnt !== 16'd0) begin
            failures++; $display("FAIL mid_idle: got busy=%b cnt=%0d expected 0 0", busy, frame_cnt);
        end
        run_to(60);
        checks++;
        if (acc_x.size() != 12 || first_acc != 41 || acc_x[0] !== 2'd0 || acc_y[0] !== 2'd0 || frame_cnt !== 16'd1) begin
            failures++;
            $display("FAIL mid_restart: got n=%0d first=%0d cnt=%0d expected n=12 first=41 at (0,0) cnt=1",
                     acc_x.size(), first_acc, frame_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_move();
        test_render();
        test_render_stall();
        test_overrun();
        test_game_over();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
